// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_skid_buf pipeline boundary.
// State encoding: EMPTY=00, BUSY=01, FULL=10; 11 is illegal and recovers to EMPTY.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } pipe_state_e;

    // Width of the optional backpressure stall counter.
    localparam int unsigned STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_data_reg.sv
// Enable-gated data register with asynchronous active-low reset.
// Holds its value whenever i_en is low, so it does not toggle when idle.
module pipe_data_reg #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] data_q;

    // Load on enable, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= RESET_VAL;
        end else if (i_en) begin
            data_q <= i_d;
        end else begin
            data_q <= data_q;
        end
    end

    assign o_q = data_q;

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer forming one pipeline boundary.
// o_ready and o_valid decode only the registered state, so there is no
// combinational path from i_ready to o_ready. i_flush empties the buffer.
// Optional feature: define PIPE_SKID_PERF_EN to add the o_stall_cnt counter.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
`ifdef PIPE_SKID_PERF_EN
    output logic [STALL_CNT_W-1:0] o_stall_cnt,
`endif
    output logic [WIDTH-1:0]       o_data
);

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             main_en_s;
    logic             skid_en_s;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Decode handshake outputs from the registered state only.
    always_comb begin
        o_valid = 1'b0;
        o_ready = 1'b1;
        case (state_q)
            ST_EMPTY: begin
                o_valid = 1'b0;
                o_ready = 1'b1;
            end
            ST_BUSY: begin
                o_valid = 1'b1;
                o_ready = 1'b1;
            end
            ST_FULL: begin
                o_valid = 1'b1;
                o_ready = 1'b0;
            end
            default: begin
                o_valid = 1'b0;
                o_ready = 1'b1;
            end
        endcase
    end

    assign in_xfer_s  = i_valid & o_ready;
    assign out_xfer_s = o_valid & i_ready;

    // Next state and data-register enables; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        main_en_s = 1'b0;
        skid_en_s = 1'b0;
        main_d    = i_data;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        main_en_s = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        state_d   = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_en_s = 1'b1;
                        state_d   = ST_BUSY;
                    end else if (in_xfer_s) begin
                        skid_en_s = 1'b1;
                        state_d   = ST_FULL;
                    end else if (out_xfer_s) begin
                        state_d   = ST_EMPTY;
                    end else begin
                        state_d   = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        main_d    = skid_q;
                        main_en_s = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        state_d   = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (main_en_s),
        .i_d     (main_d),
        .o_q     (main_q)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (skid_en_s),
        .i_d     (i_data),
        .o_q     (skid_q)
    );

    assign o_data = main_q;

`ifdef PIPE_SKID_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Count cycles where downstream backpressure holds a valid payload; wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (o_valid && !i_ready) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Self-checking bench for pipe_skid_buf: directed scenarios plus randomized
// traffic compared against a queue-based FIFO model of at most two entries.
module tb_pipe_skid_buf;

    localparam int unsigned W  = 32;
    localparam logic [W-1:0] RV = 32'hDEAD_0001;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_flush;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_data;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_data;
`ifdef PIPE_SKID_PERF_EN
    logic [31:0]  o_stall_cnt;
`endif

    int           checks;
    int           errors;
    logic [W-1:0] mq[$];
    logic [31:0]  stall_m;

    pipe_skid_buf #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
`ifdef PIPE_SKID_PERF_EN
        .o_stall_cnt (o_stall_cnt),
`endif
        .o_data      (o_data)
    );

    // 10 ns clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare DUT outputs with the model's view of the buffer.
    task automatic compare_model();
        chk("valid", 64'(o_valid), 64'(mq.size() != 0));
        chk("ready", 64'(o_ready), 64'(mq.size() < 2));
        if (mq.size() != 0) begin
            chk("data", 64'(o_data), 64'(mq[0]));
        end
`ifdef PIPE_SKID_PERF_EN
        chk("stall_cnt", 64'(o_stall_cnt), 64'(stall_m));
`endif
    endtask

    // One clock: update the FIFO model with the inputs sampled at the edge,
    // then check outputs on the falling edge.
    task automatic step();
        bit in_x;
        bit out_x;
        @(posedge i_clk);
        in_x  = i_valid && (mq.size() < 2);
        out_x = (mq.size() != 0) && i_ready;
        if ((mq.size() != 0) && !i_ready) stall_m = stall_m + 32'd1;
        if (i_flush) begin
            mq.delete();
        end else begin
            if (out_x) void'(mq.pop_front());
            if (in_x) mq.push_back(i_data);
        end
        @(negedge i_clk);
        compare_model();
    endtask

    task automatic idle_inputs();
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        mq.delete();
        stall_m = 32'd0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        stall_m = 32'd0;
        i_rst_n = 1'b0;
        idle_inputs();

        // 1: reset state
        apply_reset();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_data", 64'(o_data), 64'(RV));
        step();
`ifdef PIPE_SKID_PERF_EN
        chk("rst_stall", 64'(o_stall_cnt), 64'd0);
`endif

        // 2: full-rate streaming
        i_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            i_valid = 1'b1;
            i_data  = 32'(i);
            step();
            chk("stream_data", 64'(o_data), 64'(i));
            chk("stream_ready", 64'(o_ready), 64'd1);
        end
        i_valid = 1'b0;
        step();
        chk("stream_drained", 64'(o_valid), 64'd0);

        // 3: backpressure fills the skid entry, then drains in order
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hA;
        step();
        i_data  = 32'hB;
        step();
        chk("full_ready", 64'(o_ready), 64'd0);
        chk("full_data", 64'(o_data), 64'hA);
        i_valid = 1'b0;
        step();
        chk("full_hold", 64'(o_data), 64'hA);
        i_ready = 1'b1;
        step();
        chk("drain_b", 64'(o_data), 64'hB);
        chk("drain_ready", 64'(o_ready), 64'd1);
        step();
        chk("drain_empty", 64'(o_valid), 64'd0);

        // 4: flush from FULL with a concurrent input
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hC;
        step();
        i_data  = 32'hD;
        step();
        i_flush = 1'b1;
        i_data  = 32'hE;
        step();
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_ready", 64'(o_ready), 64'd1);
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        chk("flush_stays_empty", 64'(o_valid), 64'd0);

        // 5: asynchronous reset while BUSY
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h55;
        step();
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(o_valid), 64'd0);
        chk("async_rst_ready", 64'(o_ready), 64'd1);
        chk("async_rst_data", 64'(o_data), 64'(RV));
        mq.delete();
        stall_m = 32'd0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        chk("post_rst_data", 64'(o_data), 64'(RV));

        // 6: randomized traffic
        for (int n = 0; n < 10000; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 31) == 0);
            i_data  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
